// File: rtl/instr_decode_stage.sv
// instr_decode_stage
//   Registered instruction decoder between fetch and execute. It handles
//   12-bit (PIC16C5x) or 14-bit (mid-range) encodings, selected by INSTR_W.
//   Both sides use a valid/ready handshake. This stage also owns the annul
//   logic: a completed GOTO/CALL/RETLW, or a skip request from execute,
//   turns exactly one following instruction into an annulled NOP record.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ready   fetch-side handshake, instr_in = fetched word
//   skip_req            1-cycle pulse from execute: skip condition is true
//   out_valid/out_ready execute-side handshake for the decoded record
//   op_class            0 NOP,1 CTRL,2 BYTE,3 BITSC,4 BITSKIP,5 LIT,
//                       6 CALL,7 GOTO,8 RETLW,9 ILLEGAL
//   alu_op              byte/literal sub-opcode (bit ops: {2'b0,op bits})
//   f_addr, dest_f      file-register operand and d bit
//   bit_mask            one-hot bit select for bit ops
//   lit                 literal k (LIT, RETLW)
//   target              CALL/GOTO target, zero-extended
//   fsz                 skip-class instruction (DECFSZ, INCFSZ, BTFSC, BTFSS)
//   annul               record is a killed instruction, every field zero
//
// State  | meaning
// -------+--------------------------------------------------------------
// RUN    | normal decoding
// FLUSH  | a branch record was consumed; the next accepted word is annulled
module instr_decode_stage #(
    parameter int INSTR_W = 12,
    parameter int F_W     = 5,
    parameter int TGT_W   = 9
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] instr_in,
    input  logic               skip_req,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [3:0]         op_class,
    output logic [3:0]         alu_op,
    output logic [F_W-1:0]     f_addr,
    output logic               dest_f,
    output logic [7:0]         bit_mask,
    output logic [7:0]         lit,
    output logic [TGT_W-1:0]   target,
    output logic               fsz,
    output logic               annul
);

    localparam logic [3:0] CL_NOP     = 4'd0;
    localparam logic [3:0] CL_CTRL    = 4'd1;
    localparam logic [3:0] CL_BYTE    = 4'd2;
    localparam logic [3:0] CL_BITSC   = 4'd3;
    localparam logic [3:0] CL_BITSKIP = 4'd4;
    localparam logic [3:0] CL_LIT     = 4'd5;
    localparam logic [3:0] CL_CALL    = 4'd6;
    localparam logic [3:0] CL_GOTO    = 4'd7;
    localparam logic [3:0] CL_RETLW   = 4'd8;
    localparam logic [3:0] CL_ILLEGAL = 4'd9;

    localparam logic [0:0] ST_RUN   = 1'b0;
    localparam logic [0:0] ST_FLUSH = 1'b1;

    logic [0:0]       state;
    logic             skip_pend;

    logic [13:0]      iw;
    logic [3:0]       d_cls;
    logic [3:0]       d_alu;
    logic [F_W-1:0]   d_f;
    logic             d_d;
    logic [7:0]       d_mask;
    logic [7:0]       d_lit;
    logic [TGT_W-1:0] d_tgt;
    logic             d_fsz;

    logic accept;
    logic consume;
    logic hold;
    logic branch_done;
    logic skip_live;
    logic skip_in_place;
    logic kill_word;

    // Both decode tables index a 14-bit copy so neither branch reads past
    // the port width; the upper bits are zero in 12-bit builds.
    assign iw = 14'(instr_in);

    always_comb begin
        d_cls  = CL_NOP;
        d_alu  = '0;
        d_f    = '0;
        d_d    = 1'b0;
        d_mask = '0;
        d_lit  = '0;
        d_tgt  = '0;
        d_fsz  = 1'b0;
        if (INSTR_W == 12) begin
            priority casez (iw[11:0])
                12'b11??_????_????: begin
                    d_cls = CL_LIT;
                    d_alu = {2'b00, iw[9:8]};
                    d_lit = iw[7:0];
                end
                12'b101?_????_????: begin
                    d_cls = CL_GOTO;
                    d_tgt = TGT_W'(iw[8:0]);
                end
                12'b1001_????_????: begin
                    d_cls = CL_CALL;
                    d_tgt = TGT_W'(iw[7:0]);
                end
                12'b1000_????_????: begin
                    d_cls = CL_RETLW;
                    d_lit = iw[7:0];
                end
                12'b01??_????_????: begin
                    d_cls  = iw[9] ? CL_BITSKIP : CL_BITSC;
                    d_alu  = {2'b00, iw[9:8]};
                    d_mask = 8'b1 << iw[7:5];
                    d_f    = F_W'(iw[4:0]);
                    d_fsz  = iw[9];
                end
                12'b0000_0000_0000: d_cls = CL_NOP;
                12'b0000_0000_0???: begin
                    d_cls = CL_CTRL;
                    d_f   = F_W'(iw[2:0]);
                end
                12'b0000_000?_????: d_cls = CL_ILLEGAL;
                default: begin
                    d_cls = CL_BYTE;
                    d_alu = iw[9:6];
                    d_d   = iw[5];
                    d_f   = F_W'(iw[4:0]);
                    // DECFSZ = 1011, INCFSZ = 1111
                    d_fsz = iw[9] & iw[7] & iw[6];
                end
            endcase
        end else begin
            priority casez (iw)
                14'b11_1011_????_????: d_cls = CL_ILLEGAL;
                14'b11_00??_????_????: begin
                    d_cls = CL_LIT;
                    d_lit = iw[7:0];
                end
                14'b11_01??_????_????: begin
                    d_cls = CL_RETLW;
                    d_lit = iw[7:0];
                end
                14'b11_10??_????_????: begin
                    d_cls = CL_LIT;
                    d_alu = iw[11:8];
                    d_lit = iw[7:0];
                end
                // SUBLW/ADDLW carry a don't-care bit; it is cleared so
                // execute sees one code per operation.
                14'b11_110?_????_????: begin
                    d_cls = CL_LIT;
                    d_alu = 4'b1100;
                    d_lit = iw[7:0];
                end
                14'b11_111?_????_????: begin
                    d_cls = CL_LIT;
                    d_alu = 4'b1110;
                    d_lit = iw[7:0];
                end
                14'b10_1???_????_????: begin
                    d_cls = CL_GOTO;
                    d_tgt = TGT_W'(iw[10:0]);
                end
                14'b10_0???_????_????: begin
                    d_cls = CL_CALL;
                    d_tgt = TGT_W'(iw[10:0]);
                end
                14'b01_????_????_????: begin
                    d_cls  = iw[11] ? CL_BITSKIP : CL_BITSC;
                    d_alu  = {2'b00, iw[11:10]};
                    d_mask = 8'b1 << iw[9:7];
                    d_f    = F_W'(iw[6:0]);
                    d_fsz  = iw[11];
                end
                14'b00_0000_0??0_0000: d_cls = CL_NOP;
                14'b00_0000_0000_100?,
                14'b00_0000_0110_0011,
                14'b00_0000_0110_0100: begin
                    d_cls = CL_CTRL;
                    d_f   = F_W'(iw[6:0]);
                end
                14'b00_0000_0???_????: d_cls = CL_ILLEGAL;
                default: begin
                    d_cls = CL_BYTE;
                    d_alu = iw[11:8];
                    d_d   = iw[7];
                    d_f   = F_W'(iw[6:0]);
                    d_fsz = iw[11] & iw[9] & iw[8];
                end
            endcase
        end
    end

    assign in_ready    = ~rst & (~out_valid | out_ready);
    assign accept      = in_valid & in_ready;
    assign consume     = out_valid & out_ready;
    assign hold        = out_valid & ~out_ready;
    assign branch_done = consume & (op_class inside {CL_CALL, CL_GOTO, CL_RETLW});
    assign skip_live   = skip_req & ~skip_pend;
    assign skip_in_place = skip_live & hold;

    // A word accepted in the same cycle that a branch leaves, or that a
    // skip arrives with nothing held, is itself the follower to kill.
    // All sources collapse into one annul.
    assign kill_word = (state == ST_FLUSH) | branch_done | skip_pend
                     | (skip_live & ~hold);

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            state     <= ST_RUN;
            skip_pend <= 1'b0;
            op_class  <= '0;
            alu_op    <= '0;
            f_addr    <= '0;
            dest_f    <= 1'b0;
            bit_mask  <= '0;
            lit       <= '0;
            target    <= '0;
            fsz       <= 1'b0;
            annul     <= 1'b0;
        end else begin
            if (accept) begin
                out_valid <= 1'b1;
                op_class  <= kill_word ? CL_NOP : d_cls;
                alu_op    <= kill_word ? '0 : d_alu;
                f_addr    <= kill_word ? '0 : d_f;
                dest_f    <= kill_word ? 1'b0 : d_d;
                bit_mask  <= kill_word ? '0 : d_mask;
                lit       <= kill_word ? '0 : d_lit;
                target    <= kill_word ? '0 : d_tgt;
                fsz       <= kill_word ? 1'b0 : d_fsz;
                annul     <= kill_word;
            end else if (consume) begin
                out_valid <= 1'b0;
            end else if (skip_in_place) begin
                op_class  <= CL_NOP;
                alu_op    <= '0;
                f_addr    <= '0;
                dest_f    <= 1'b0;
                bit_mask  <= '0;
                lit       <= '0;
                target    <= '0;
                fsz       <= 1'b0;
                annul     <= 1'b1;
            end

            if (accept) begin
                state <= ST_RUN;
            end else if (branch_done) begin
                state <= ST_FLUSH;
            end

            if (accept) begin
                skip_pend <= 1'b0;
            end else if (skip_live & ~hold) begin
                skip_pend <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_instr_decode_stage.sv
// Bench for instr_decode_stage: one 12-bit and one 14-bit instance share the
// handshake stimulus; each is compared against a stream-level reference
// model every cycle, plus directed checks of the documented examples.
module tb_instr_decode_stage;

    localparam logic [3:0] C_NOP = 4'd0, C_CTRL = 4'd1, C_BYTE = 4'd2;
    localparam logic [3:0] C_BIT = 4'd3, C_BSK = 4'd4, C_LIT = 4'd5;
    localparam logic [3:0] C_CALL = 4'd6, C_GOTO = 4'd7, C_RETLW = 4'd8;
    localparam logic [3:0] C_ILL = 4'd9;

    typedef struct packed {
        logic [3:0]  cls;
        logic [3:0]  alu;
        logic [6:0]  f;
        logic        d;
        logic [7:0]  mask;
        logic [7:0]  lit;
        logic [10:0] tgt;
        logic        fsz;
        logic        annul;
    } rec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, in_valid, out_ready, skip_req;
    logic [11:0] instr12;
    logic [13:0] instr14;

    logic        ir12, ov12, d12, fsz12, an12;
    logic [3:0]  oc12, alu12;
    logic [4:0]  f12;
    logic [7:0]  mask12, lit12;
    logic [8:0]  tgt12;

    logic        ir14, ov14, d14, fsz14, an14;
    logic [3:0]  oc14, alu14;
    logic [6:0]  f14;
    logic [7:0]  mask14, lit14;
    logic [10:0] tgt14;

    instr_decode_stage #(.INSTR_W(12), .F_W(5), .TGT_W(9)) dut12 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir12),
        .instr_in(instr12), .skip_req(skip_req), .out_valid(ov12),
        .out_ready(out_ready), .op_class(oc12), .alu_op(alu12), .f_addr(f12),
        .dest_f(d12), .bit_mask(mask12), .lit(lit12), .target(tgt12),
        .fsz(fsz12), .annul(an12)
    );

    instr_decode_stage #(.INSTR_W(14), .F_W(7), .TGT_W(11)) dut14 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir14),
        .instr_in(instr14), .skip_req(skip_req), .out_valid(ov14),
        .out_ready(out_ready), .op_class(oc14), .alu_op(alu14), .f_addr(f14),
        .dest_f(d14), .bit_mask(mask14), .lit(lit14), .target(tgt14),
        .fsz(fsz14), .annul(an14)
    );

    int n_vec = 0;
    int n_err = 0;

    logic mv[2];
    logic mkill[2];
    rec_t mrec[2];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference decode for the 12-bit set, by opcode ranges.
    function automatic rec_t ref12(input int v);
        rec_t r;
        int   sub, op;
        r = '0;
        if (v >= 'hC00) begin
            r.cls = C_LIT; r.alu = 4'((v - 'hC00) / 256); r.lit = 8'(v % 256);
        end else if (v >= 'hA00) begin
            r.cls = C_GOTO; r.tgt = 11'(v - 'hA00);
        end else if (v >= 'h900) begin
            r.cls = C_CALL; r.tgt = 11'(v - 'h900);
        end else if (v >= 'h800) begin
            r.cls = C_RETLW; r.lit = 8'(v % 256);
        end else if (v >= 'h400) begin
            sub = (v - 'h400) / 256;
            r.cls = (sub >= 2) ? C_BSK : C_BIT;
            r.alu = 4'(sub);
            r.mask = 8'(1 << ((v / 32) % 8));
            r.f = 7'(v % 32);
            r.fsz = (sub >= 2);
        end else if (v == 0) begin
            r.cls = C_NOP;
        end else if (v < 8) begin
            r.cls = C_CTRL; r.f = 7'(v);
        end else if (v < 32) begin
            r.cls = C_ILL;
        end else begin
            op = v / 64;
            r.cls = C_BYTE; r.alu = 4'(op); r.d = 1'((v / 32) % 2);
            r.f = 7'(v % 32); r.fsz = (op == 11 || op == 15);
        end
        return r;
    endfunction

    // Reference decode for the 14-bit mid-range set.
    function automatic rec_t ref14(input int v);
        rec_t r;
        int   sub, op;
        r = '0;
        if (v >= 'h3000) begin
            sub = (v - 'h3000) / 256;
            r.lit = 8'(v % 256);
            if (sub < 4) begin r.cls = C_LIT; end
            else if (sub < 8) begin r.cls = C_RETLW; end
            else if (sub <= 10) begin r.cls = C_LIT; r.alu = 4'(sub); end
            else if (sub == 11) begin r.cls = C_ILL; r.lit = 8'h00; end
            else if (sub < 14) begin r.cls = C_LIT; r.alu = 4'd12; end
            else begin r.cls = C_LIT; r.alu = 4'd14; end
        end else if (v >= 'h2800) begin
            r.cls = C_GOTO; r.tgt = 11'(v - 'h2800);
        end else if (v >= 'h2000) begin
            r.cls = C_CALL; r.tgt = 11'(v - 'h2000);
        end else if (v >= 'h1000) begin
            sub = (v - 'h1000) / 1024;
            r.cls = (sub >= 2) ? C_BSK : C_BIT;
            r.alu = 4'(sub);
            r.mask = 8'(1 << ((v / 128) % 8));
            r.f = 7'(v % 128);
            r.fsz = (sub >= 2);
        end else if (v < 128) begin
            if (v == 0 || v == 'h20 || v == 'h40 || v == 'h60) r.cls = C_NOP;
            else if (v == 8 || v == 9 || v == 'h63 || v == 'h64) begin
                r.cls = C_CTRL; r.f = 7'(v);
            end else r.cls = C_ILL;
        end else begin
            op = v / 256;
            r.cls = C_BYTE; r.alu = 4'(op); r.d = 1'((v / 128) % 2);
            r.f = 7'(v % 128); r.fsz = (op == 11 || op == 15);
        end
        return r;
    endfunction

    // Stream-level model: a branch leaving the stage or a skip that finds
    // nothing held marks the next instruction in the stream for killing.
    task automatic model_tick(input int k, input int w);
        logic hold, consume, accept, pending;
        rec_t dec;
        if (rst) begin
            mv[k] = 1'b0; mkill[k] = 1'b0; mrec[k] = '0;
            return;
        end
        hold    = mv[k] && !out_ready;
        consume = mv[k] && out_ready;
        accept  = in_valid && !hold;
        pending = mkill[k] || (consume && (mrec[k].cls inside {C_CALL, C_GOTO, C_RETLW}))
                  || (skip_req && !hold);
        if (accept) begin
            dec = (k == 0) ? ref12(w) : ref14(w);
            if (pending) begin
                dec = '0; dec.annul = 1'b1;
            end
            mrec[k] = dec; mv[k] = 1'b1; mkill[k] = 1'b0;
        end else begin
            mkill[k] = pending;
            if (consume) mv[k] = 1'b0;
            else if (skip_req && hold) begin
                mrec[k] = '0; mrec[k].annul = 1'b1;
            end
        end
    endtask

    function automatic rec_t rec12();
        rec_t r;
        r.cls = oc12; r.alu = alu12; r.f = 7'(f12); r.d = d12; r.mask = mask12;
        r.lit = lit12; r.tgt = 11'(tgt12); r.fsz = fsz12; r.annul = an12;
        return r;
    endfunction

    function automatic rec_t rec14();
        rec_t r;
        r.cls = oc14; r.alu = alu14; r.f = f14; r.d = d14; r.mask = mask14;
        r.lit = lit14; r.tgt = tgt14; r.fsz = fsz14; r.annul = an14;
        return r;
    endfunction

    // Called just after a falling edge: apply inputs, check in_ready, advance
    // the model, then compare the registered outputs at the next falling edge.
    task automatic drive(input logic r, input logic iv, input int w12, input int w14,
                         input logic ordy, input logic skp);
        rst = r; in_valid = iv; instr12 = 12'(w12); instr14 = 14'(w14);
        out_ready = ordy; skip_req = skp;
        #1;
        chk("in_ready12", ir12, !r && (!mv[0] || ordy));
        chk("in_ready14", ir14, !r && (!mv[1] || ordy));
        model_tick(0, int'(instr12));
        model_tick(1, int'(instr14));
        @(posedge clk);
        @(negedge clk);
        chk("out_valid12", ov12, mv[0]);
        chk("out_valid14", ov14, mv[1]);
        if (mv[0]) chk("record12", rec12(), mrec[0]);
        if (mv[1]) chk("record14", rec14(), mrec[1]);
    endtask

    int ctrl14[8];

    initial begin
        ctrl14 = '{0, 'h20, 8, 9, 'h63, 'h64, 'h62, 'h0C};
        mv[0] = 1'b0; mv[1] = 1'b0; mkill[0] = 1'b0; mkill[1] = 1'b0;
        mrec[0] = '0; mrec[1] = '0;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; skip_req = 1'b0;
        instr12 = '0; instr14 = '0;
        @(negedge clk);
        drive(1, 0, 0, 0, 0, 0);
        drive(1, 1, 'hC5A, 'h1783, 1, 0);
        chk("rst_valid12", ov12, 1'b0);
        chk("rst_rec12", rec12(), 0);
        chk("rst_rec14", rec14(), 0);

        // Literal and bit-set decode, latency one.
        drive(0, 1, 'hC5A, 'h1783, 1, 0);
        chk("t1_cls", oc12, C_LIT);
        chk("t1_lit", lit12, 8'h5A);
        chk("t1_alu", alu12, 4'd0);
        chk("t1_annul", an12, 1'b0);
        chk("t6_bit_cls", oc14, C_BIT);
        chk("t6_bit_mask", mask14, 8'h80);
        chk("t6_bit_f", f14, 7'h03);

        // BTFSS decode, then in-place annul while held.
        drive(0, 1, 'h7E3, 'h2805, 1, 0);
        chk("t2_cls", oc12, C_BSK);
        chk("t2_mask", mask12, 8'h80);
        chk("t2_f", f12, 5'h03);
        chk("t2_fsz", fsz12, 1'b1);
        chk("t6_goto_cls", oc14, C_GOTO);
        chk("t6_goto_tgt", tgt14, 11'h005);
        drive(0, 0, 0, 0, 0, 1);
        chk("t2_inplace_annul", an12, 1'b1);
        chk("t2_inplace_cls", oc12, C_NOP);
        drive(0, 0, 0, 0, 0, 0);

        // GOTO kills exactly the following word.
        drive(0, 1, 'hA05, 'h0B85, 1, 0);
        chk("t3_goto_cls", oc12, C_GOTO);
        chk("t3_goto_tgt", tgt12, 9'h005);
        drive(0, 1, 'h0C3, 'h3A0F, 1, 0);
        chk("t3_kill_annul", an12, 1'b1);
        chk("t3_kill_cls", oc12, C_NOP);
        drive(0, 1, 'hC12, 'h0000, 1, 0);
        chk("t3_third_annul", an12, 1'b0);
        chk("t3_third_lit", lit12, 8'h12);

        // Backpressure then release.
        for (int i = 0; i < 5; i++) drive(0, 1, 'h100 + i, 'h0100 + i, 0, 0);
        chk("t4_held_lit", lit12, 8'h12);
        for (int i = 0; i < 6; i++) drive(0, 1, 'h200 + 65 * i, 'h0900 + 3 * i, 1, 0);

        // Reset while FLUSH is pending.
        drive(0, 1, 'hA05, 'h2805, 1, 0);
        drive(0, 0, 0, 0, 1, 0);
        drive(1, 0, 0, 0, 1, 0);
        chk("t5_rst_valid", ov12, 1'b0);
        drive(0, 1, 'hCC3, 'h30C3, 1, 0);
        chk("t5_cls", oc12, C_LIT);
        chk("t5_lit", lit12, 8'hC3);
        chk("t5_annul", an12, 1'b0);

        for (int n = 0; n < 3000; n++) begin
            int w14;
            w14 = ($urandom_range(0, 7) == 0) ? ctrl14[$urandom_range(0, 7)]
                                              : int'($urandom_range(0, 16383));
            drive($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0,
                  int'($urandom_range(0, 4095)), w14,
                  $urandom_range(0, 9) < 7, $urandom_range(0, 9) == 0);
        end
        for (int n = 0; n < 3; n++) drive(0, 0, 0, 0, 1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
